// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, instruction formats and the decoded bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_e;

  // imm is sized for the widest datapath; narrower stages use the low bits.
  typedef struct packed {
    logic [6:0]  op_code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    fmt_e        fmt;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  localparam decoded_t DEC_RESET = '{
    op_code: '0, rd: '0, rs1: '0, rs2: '0, funct3: '0, funct7: '0,
    imm: '0, fmt: FMT_ILLEGAL, rd_we: 1'b0, illegal: 1'b0
  };

endpackage

// File: rtl/riscv_decode_comb.sv
// Combinational instruction decoder: field extraction, format classification, immediates.
module riscv_decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned Bitness = 32
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic        sgn;
  logic [63:0] imm_full;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;

  assign sgn = instr[31];

  always_comb begin
    dec          = DEC_RESET;
    dec.op_code  = instr[6:0];
    dec.funct3   = instr[14:12];
    dec.funct7   = instr[31:25];
    imm_full     = '0;
    // Every legal opcode ends in 2'b11, so a bad instr[1:0] falls through to default.
    unique case (instr[6:0])
      OP_OP: dec.fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
        dec.fmt  = FMT_I;
        imm_full = {{52{sgn}}, instr[31:20]};
      end
      OP_STORE: begin
        dec.fmt  = FMT_S;
        imm_full = {{52{sgn}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt  = FMT_B;
        imm_full = {{51{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt  = FMT_U;
        imm_full = {{32{sgn}}, instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt  = FMT_J;
        imm_full = {{43{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: dec.fmt = FMT_ILLEGAL;
    endcase

    use_rd  = dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    use_rs1 = dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2 = dec.fmt inside {FMT_R, FMT_S, FMT_B};

    dec.rd      = use_rd  ? instr[11:7]  : '0;
    dec.rs1     = use_rs1 ? instr[19:15] : '0;
    dec.rs2     = use_rs2 ? instr[24:20] : '0;
    dec.rd_we   = use_rd && (instr[11:7] != 5'd0);
    dec.illegal = (dec.fmt == FMT_ILLEGAL);
    dec.imm     = (Bitness == 32) ? {32'b0, imm_full[31:0]} : imm_full;
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode pipeline stage: registered valid/ready output with a one-entry skid buffer.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned Bitness    = 32,
  parameter bit          SkidEnable = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [Bitness-1:0] in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Bitness-1:0] out_pc,
  output logic [6:0]         out_op_code,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [Bitness-1:0] out_imm,
  output logic [2:0]         out_fmt,
  output logic               out_rd_we,
  output logic               out_illegal
);

  decoded_t           dec;
  decoded_t           out_q;
  decoded_t           skid_q;
  logic [Bitness-1:0] out_pc_q;
  logic [Bitness-1:0] skid_pc_q;
  logic               out_valid_q;
  logic               skid_free_q;
  logic               in_take;
  logic               out_free;

  riscv_decode_comb #(.Bitness(Bitness)) u_comb (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = SkidEnable ? skid_free_q : (!out_valid_q || out_ready);
  assign in_take  = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  // The skid is only ever loaded while the output register is stalled, so it drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      skid_free_q <= 1'b1;
      out_q       <= DEC_RESET;
      skid_q      <= DEC_RESET;
      out_pc_q    <= '0;
      skid_pc_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_free_q <= 1'b1;
    end else if (out_free) begin
      if (!skid_free_q) begin
        out_q       <= skid_q;
        out_pc_q    <= skid_pc_q;
        out_valid_q <= 1'b1;
        skid_free_q <= 1'b1;
      end else begin
        out_valid_q <= in_take;
        if (in_take) begin
          out_q    <= dec;
          out_pc_q <= in_pc;
        end
      end
    end else if (in_take) begin
      skid_q      <= dec;
      skid_pc_q   <= in_pc;
      skid_free_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_op_code = out_q.op_code;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = Bitness'(out_q.imm);
  assign out_fmt     = out_q.fmt;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed self-checking bench for riscv_decode_stage (32-bit and 64-bit instances).
module tb_riscv_decode_stage;

  logic clk, rst, flush;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_op_code, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rd_we, out_illegal;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_pc, w_out_pc, w_out_imm;
  logic [6:0]  w_out_op_code, w_out_funct7;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0]  w_out_funct3, w_out_fmt;
  logic        w_out_rd_we, w_out_illegal;

  int passed = 0;
  int total  = 0;

  riscv_decode_stage #(.Bitness(32), .SkidEnable(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op_code(out_op_code), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  riscv_decode_stage #(.Bitness(64), .SkidEnable(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .out_op_code(w_out_op_code), .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
    .out_funct3(w_out_funct3), .out_funct7(w_out_funct7), .out_imm(w_out_imm),
    .out_fmt(w_out_fmt), .out_rd_we(w_out_rd_we), .out_illegal(w_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } vec_t;

  // fmt codes: R=0 I=1 S=2 B=3 U=4 J=5 ILLEGAL=6
  vec_t vecs [9] = '{
    '{32'hFFF10093, 3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h00512423, 3'd2, 5'd0, 5'd2, 5'd5, 32'h00000008, 1'b0, 1'b0},
    '{32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0},
    '{32'h123451B7, 3'd4, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b0},
    '{32'h00000000, 3'd6, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1},
    '{32'h0000007F, 3'd6, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1},
    '{32'hFFFFFFFF, 3'd6, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1},
    '{32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b1, 1'b0},
    '{32'h00000013, 3'd1, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input int idx, input logic [31:0] pc);
    vec_t v;
    logic [31:0] ins;
    v   = vecs[idx];
    ins = v.instr;
    check($sformatf("v%0d.valid", idx), 64'(out_valid), 64'd1);
    check($sformatf("v%0d.pc", idx), 64'(out_pc), 64'(pc));
    check($sformatf("v%0d.op", idx), 64'(out_op_code), 64'(ins[6:0]));
    check($sformatf("v%0d.funct3", idx), 64'(out_funct3), 64'(ins[14:12]));
    check($sformatf("v%0d.funct7", idx), 64'(out_funct7), 64'(ins[31:25]));
    check($sformatf("v%0d.fmt", idx), 64'(out_fmt), 64'(v.fmt));
    check($sformatf("v%0d.rd", idx), 64'(out_rd), 64'(v.rd));
    check($sformatf("v%0d.rs1", idx), 64'(out_rs1), 64'(v.rs1));
    check($sformatf("v%0d.rs2", idx), 64'(out_rs2), 64'(v.rs2));
    check($sformatf("v%0d.imm", idx), 64'(out_imm), 64'(v.imm));
    check($sformatf("v%0d.rd_we", idx), 64'(out_rd_we), 64'(v.we));
    check($sformatf("v%0d.illegal", idx), 64'(out_illegal), 64'(v.ill));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_out_ready = 1'b0;
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.fmt", 64'(out_fmt), 64'd6);
    check("rst.illegal", 64'(out_illegal), 64'd0);
    check("rst.imm", 64'(out_imm), 64'd0);
    check("rst.pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream with out_ready high: one result per cycle, no bubbles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_instr = vecs[i].instr;
      in_pc    = 32'h100 + 32'(i * 4);
      tick();
      expect_vec(i, 32'h100 + 32'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // Stall: first held stable, second lands in skid, then both drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h200;
    tick();
    check("stall.pc0", 64'(out_pc), 64'h200);
    check("stall.in_ready0", 64'(in_ready), 64'd1);
    in_instr = 32'h00512423; in_pc = 32'h204;
    tick();
    in_valid = 1'b0;
    check("stall.pc1", 64'(out_pc), 64'h200);
    check("stall.in_ready1", 64'(in_ready), 64'd0);
    tick();
    check("stall.hold_valid", 64'(out_valid), 64'd1);
    check("stall.hold_pc", 64'(out_pc), 64'h200);
    check("stall.hold_imm", 64'(out_imm), 64'hFFFFFFFF);
    check("stall.hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("skid.valid", 64'(out_valid), 64'd1);
    check("skid.pc", 64'(out_pc), 64'h204);
    check("skid.fmt", 64'(out_fmt), 64'd2);
    check("skid.imm", 64'(out_imm), 64'd8);
    check("skid.in_ready", 64'(in_ready), 64'd1);
    tick();
    check("skid.drained", 64'(out_valid), 64'd0);

    // Flush with output full, skid full and a new input offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h300;
    tick();
    in_instr = 32'h008000EF; in_pc = 32'h304;
    tick();
    check("pre_flush.valid", 64'(out_valid), 64'd1);
    check("pre_flush.in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'hFFF10093; in_pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("flush.quiet%0d", i), 64'(out_valid), 64'd0);
    end

    // Flush drops an input even when in_valid && in_ready.
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h310; flush = 1'b1;
    check("flush2.in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2.out_valid", 64'(out_valid), 64'd0);
    tick();
    check("flush2.quiet", 64'(out_valid), 64'd0);

    // 64-bit datapath: U immediate sign-extends from bit 31, I immediate to full width.
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_instr = 32'h800000B7; w_in_pc = 64'h8000_0000_0000_1000;
    tick();
    check("w.lui.valid", 64'(w_out_valid), 64'd1);
    check("w.lui.pc", w_out_pc, 64'h8000_0000_0000_1000);
    check("w.lui.imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
    check("w.lui.fmt", 64'(w_out_fmt), 64'd4);
    check("w.lui.rd", 64'(w_out_rd), 64'd1);
    check("w.lui.rd_we", 64'(w_out_rd_we), 64'd1);
    w_in_instr = 32'hFFF10093; w_in_pc = 64'h8000_0000_0000_1004;
    tick();
    check("w.addi.imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w.addi.pc", w_out_pc, 64'h8000_0000_0000_1004);
    check("w.addi.valid", 64'(w_out_valid), 64'd1);

    // Asynchronous reset mid-stream, away from any clock edge.
    in_valid = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h500;
    tick();
    check("mid.valid32", 64'(out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("arst.w_valid", 64'(w_out_valid), 64'd0);
    check("arst.w_in_ready", 64'(w_in_ready), 64'd1);
    check("arst.w_imm", w_out_imm, 64'd0);
    check("arst.w_fmt", 64'(w_out_fmt), 64'd6);
    check("arst.valid32", 64'(out_valid), 64'd0);
    in_valid = 1'b0; w_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst.valid32", 64'(out_valid), 64'd0);
    check("post_rst.w_valid", 64'(w_out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
Pipelined RISC-V RV32I/RV64I decode stage between fetch and execute. Accepts an instruction word and PC over a valid/ready handshake. Extracts fields, classifies the format as R/I/S/B/U/J and builds the sign-extended immediate at full Bitness. Presents the result on a registered valid/ready output, backed by a one-entry skid buffer so that in_ready is a flop output. Supports pipeline flush.

Parameters:
Bitness, 32, datapath/PC/immediate width; legal values 32 or 64
SkidEnable, 1, 1 = skid buffer present (in_ready registered); 0 = in_ready = !out_valid || out_ready

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
flush  input  1  discard all held and incoming instructions this cycle
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction
in_instr  input  32  instruction word
in_pc  input  Bitness  PC of in_instr
out_valid  output  1  decoded instruction valid
out_ready  input  1  downstream accepts
out_pc  output  Bitness  PC of the decoded instruction
out_op_code  output  7  instr[6:0]
out_rd  output  5  instr[11:7]; 0 when the format has no rd
out_rs1  output  5  instr[19:15]; 0 when unused
out_rs2  output  5  instr[24:20]; 0 when unused
out_funct3  output  3  instr[14:12]
out_funct7  output  7  instr[31:25]
out_imm  output  Bitness  sign-extended immediate; 0 for R-format
out_fmt  output  3  fmt_e encoding
out_rd_we  output  1  instruction writes rd, and rd != 0
out_illegal  output  1  unrecognised opcode or instr[1:0] != 2'b11

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, skid empty. All out_* data = 0; out_fmt=FMT_ILLEGAL; out_illegal=0.
- Transfer rules:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_* must hold stable while out_valid && !out_ready.
- Latency: 1 cycle. A transfer at edge N appears on out_* after edge N.
- Throughput: 1 instruction/cycle while out_ready is held high.
- Skid (SkidEnable=1):
  - in_ready = !skid_full (registered).
  - Input accepted while out_valid && !out_ready → decoded word goes to skid; in_ready=0 next cycle.
  - On output transfer with skid full → skid moves to the output register; in_ready=1 next cycle.
  - Order is strictly preserved.
- Decode is combinational on in_instr in the sub-module; results are registered.
- Opcode → format map:
  - 0110011 → R
  - 0010011 / 0000011 / 1100111 / 0001111 / 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111 / 0010111 → U
  - 1101111 → J
  - anything else → FMT_ILLEGAL with out_illegal=1
- Immediates (sign bit is instr[31], extended to Bitness):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when Bitness=64
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Register-usage masks:
  - rs1 used by R/I/S/B; rs2 used by R/S/B; rd used by R/I/U/J.
  - Unused fields are forced to 0.
  - out_rd_we = rd used && rd != 0.
- Illegal instructions still flow through the pipe with out_illegal=1, out_rd_we=0 and out_imm=0.
- flush (takes priority over all else in the same cycle):
  - Clears out_valid and skid; in_ready=1 next cycle.
  - Any input presented in the flush cycle is dropped, even if in_valid && in_ready.
- Reset mid-operation: all in-flight instructions are lost; state returns to the reset values.

Decomposition:
- Package riscv_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM)
  - typedef enum logic [2:0] fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL}
  - packed struct decoded_t holding all out_* data fields
- Sub-module riscv_decode_comb #(Bitness): pure combinational in_instr → decoded_t. The stage holds only the handshake, output register and skid.

Test Plan:
- Reset, then in_instr=0xFFF10093 (addi x1,x2,-1), pc=0x100, out_ready=1 → next cycle: out_valid=1, fmt=I, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, rd_we=1, pc=0x100.
- Stream 0x00512423 (sw x5,8(x2)), 0xFE000EE3 (beq x0,x0,-4), 0x123451B7 (lui x3,0x12345) back-to-back → S imm=8, rd_we=0; B imm=0xFFFFFFFC; U imm=0x12345000, rd=3; one output per cycle with no bubbles.
- out_ready=0 while two instructions are sent → first held stable, second lands in skid, in_ready=0; raise out_ready → both delivered in order, in_ready returns to 1.
- Assert flush with out_valid=1, skid full and in_valid=1 in the same cycle → out_valid=0 and in_ready=1 next cycle; none of the three instructions ever appears on the output.
- in_instr=0x00000000 and 0x0000007F → out_illegal=1, fmt=FMT_ILLEGAL, rd_we=0, imm=0.
- Bitness=64, lui with instr[31]=1 (0x800000B7) → imm=0xFFFFFFFF80000000; assert rst mid-stream → out_valid drops asynchronously.
